fpu_issue_sequencer: RTL and testbench
======================================

Name: fpu_issue_sequencer

Overview:
- Issue and sequencing controller for the floating-point unit.
- Accepts add/sub/mul/div requests over a valid/ready handshake and clocks the shared pipelined add/sub datapath by generating stage enables, per-stage valid bits and per-stage OpSel.
- Starts the iterative mul/div unit and merges its result into the shared normalize/exponent-select stage (OpSel=1 path).
- Guarantees in-order completion and full back-pressure from the result consumer.

Parameters:
- NUM_STAGES, 4, number of pipeline stages in the add/sub datapath; stage NUM_STAGES-1 drives the result.
- MERGE_STAGE, 2, index of the stage holding the adder/LZC/exponent-mux logic where mul/div results enter; legal range 1..NUM_STAGES-1.
- TAG_WIDTH, 4, width of the request tag carried to the output.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  request valid.
- InReady  output  1  request accepted when InValid & InReady.
- InOp  input  2  00 add, 01 sub, 10 mul, 11 div.
- InTag  input  TAG_WIDTH  request tag.
- StageEn  output  NUM_STAGES  per-stage register enable for the datapath.
- StageValid  output  NUM_STAGES  stage i holds a live operation.
- StageOpSel  output  NUM_STAGES  per-stage OpSel (0 add/sub, 1 mul/div).
- MdStart  output  1  one-cycle start pulse to the mul/div unit.
- MdIsDiv  output  1  valid with MdStart; 1 = divide.
- MdDone  input  1  one-cycle pulse, mul/div result ready.
- OutValid  output  1  equals StageValid[NUM_STAGES-1].
- OutReady  input  1  consumer accepts the result.
- OutTag  output  TAG_WIDTH  tag of the result.
- Busy  output  1  any stage valid, or FSM not in IDLE.

Behaviour:
- Reset (async, active-high) clears:
  - all StageValid, StageOpSel and stage tags;
  - MdStart and MdIsDiv;
  - FSM to IDLE.
- Reset mid-operation discards in-flight ops; the mul/div unit shares the same Reset.
- Advance = ~(OutValid & ~OutReady). This is a global stall: StageEn[i] = Advance for all i, so a stall holds every stage.
- On Advance:
  - stage i takes stage i-1 (valid, OpSel, tag);
  - stage 0 loads the accepted add/sub request, otherwise a bubble (valid=0).
- InReady = Advance & (State==IDLE).
- Add/sub accept: stage 0 gets valid=1, OpSel=0, tag=InTag. Latency from accept to OutValid is NUM_STAGES cycles when there is no stall.
- Mul/div accept:
  - MdStart=1 for exactly one cycle, with MdIsDiv=InOp[0];
  - InTag is captured into MdTag;
  - FSM goes IDLE->MD_WAIT;
  - stage 0 loads a bubble.
- FSM states:
  - IDLE: accepts requests; MdDone is ignored.
  - MD_WAIT: no accepts. MdDone & CanInject -> inject, ->IDLE. MdDone & ~CanInject -> MD_HOLD.
  - MD_HOLD: result pending. CanInject -> inject, ->IDLE.
- CanInject = Advance & (StageValid[MERGE_STAGE-1:0]==0). This guarantees every earlier add/sub is already past MERGE_STAGE, so order is preserved.
- Inject: stage MERGE_STAGE loads valid=1, OpSel=1, tag=MdTag in the same edge as the shift.
- Simultaneous events:
  - A stall at MdDone delays injection; it is never dropped.
  - OutReady rising in the same cycle as MdDone allows an immediate inject.
- Throughput: one add/sub per cycle. A mul/div blocks issue until its result is injected; the next request is accepted in the cycle after injection.
- OutValid/OutTag stay stable while OutValid & ~OutReady.

Optional Feature:
- Macro FPU_SEQ_PERF_CNT_EN.
- When defined, adds two outputs:
  - IssueCount (16-bit): increments on each accept.
  - StallCount (16-bit): increments each cycle Advance=0.
  - Both saturate at 16'hFFFF and are cleared by Reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then 3 back-to-back adds (tags 1,2,3), OutReady=1 -> OutValid on cycles 4,5,6 after the first accept, OutTag 1,2,3, StageOpSel all 0.
- Add tag 5 with OutReady=0 from cycle 4 for 3 cycles -> OutValid held, OutTag=5 stable, StageEn=0, InReady=0; released on the cycle OutReady=1.
- Add tag 1 then mul tag 2, MdDone 1 cycle after MdStart -> injection waits until stages 0..1 are empty; output order 1 then 2, OutOpSel=1 for tag 2.
- Div tag 7 with MdDone arriving while OutValid & ~OutReady -> FSM in MD_HOLD, injection on the first Advance cycle, MdIsDiv=1 seen with MdStart.
- Assert Reset while a mul is in MD_WAIT and 2 adds are in flight -> all StageValid=0, InReady=1 the cycle after release, and a late MdDone is ignored.
- With FPU_SEQ_PERF_CNT_EN: 5 accepts and 3 stall cycles -> IssueCount=5, StallCount=3; forcing 70000 stall cycles -> StallCount=16'hFFFF.

Source files
------------

// File: rtl/fpu_issue_sequencer.sv
// fpu_issue_sequencer: issue/sequencing controller for the FPU.
// Drives the shared add/sub pipeline (stage enables, valids, OpSel, tags),
// starts the iterative mul/div unit and merges its result at MERGE_STAGE
// while keeping completion in order under full output back-pressure.
// Optional build macro: FPU_SEQ_PERF_CNT_EN adds IssueCount/StallCount.
module fpu_issue_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned MERGE_STAGE = 2,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            InOp,
  input  logic [TAG_WIDTH-1:0]  InTag,
  output logic [NUM_STAGES-1:0] StageEn,
  output logic [NUM_STAGES-1:0] StageValid,
  output logic [NUM_STAGES-1:0] StageOpSel,
  output logic                  MdStart,
  output logic                  MdIsDiv,
  input  logic                  MdDone,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [TAG_WIDTH-1:0]  OutTag,
  output logic                  Busy
`ifdef FPU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]           IssueCount,
  output logic [15:0]           StallCount
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MD_WAIT = 2'd1;
  localparam logic [1:0] MD_HOLD = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [NUM_STAGES-1:0]                valid_q, valid_d;
  logic [NUM_STAGES-1:0]                opsel_q, opsel_d;
  logic [NUM_STAGES-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
  logic [TAG_WIDTH-1:0]                 md_tag_q, md_tag_d;
  logic                                 md_start_q, md_start_d;
  logic                                 md_is_div_q, md_is_div_d;

  logic advance;
  logic idle;
  logic in_ready;
  logic accept;
  logic accept_md;
  logic accept_as;
  logic can_inject;
  logic inject;

  // Global stall, issue handshake and merge-slot availability
  always_comb begin
    advance    = ~(valid_q[NUM_STAGES-1] & ~OutReady);
    idle       = (state_q == IDLE);
    in_ready   = advance & idle;
    accept     = InValid & in_ready;
    accept_md  = accept & InOp[1];
    accept_as  = accept & ~InOp[1];
    // Stages ahead of the merge point must be empty so no older add/sub is overtaken
    can_inject = advance & (valid_q[MERGE_STAGE-1:0] == '0);
  end

  // Mul/div sequencing FSM: start pulse, wait for result, hold until the merge slot frees
  always_comb begin
    state_d     = state_q;
    md_tag_d    = md_tag_q;
    md_start_d  = 1'b0;
    md_is_div_d = md_is_div_q;
    inject      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_md) begin
          state_d     = MD_WAIT;
          md_tag_d    = InTag;
          md_start_d  = 1'b1;
          md_is_div_d = InOp[0];
        end
      end
      MD_WAIT: begin
        if (MdDone) begin
          if (can_inject) begin
            inject  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MD_HOLD;
          end
        end
      end
      MD_HOLD: begin
        if (can_inject) begin
          inject  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline shift with add/sub entry at stage 0 and mul/div entry at MERGE_STAGE
  always_comb begin
    valid_d = valid_q;
    opsel_d = opsel_q;
    tag_d   = tag_q;
    if (advance) begin
      for (int i = 1; i < int'(NUM_STAGES); i++) begin
        valid_d[i] = valid_q[i-1];
        opsel_d[i] = opsel_q[i-1];
        tag_d[i]   = tag_q[i-1];
      end
      valid_d[0] = accept_as;
      opsel_d[0] = 1'b0;
      tag_d[0]   = accept_as ? InTag : '0;
      if (inject) begin
        valid_d[MERGE_STAGE] = 1'b1;
        opsel_d[MERGE_STAGE] = 1'b1;
        tag_d[MERGE_STAGE]   = md_tag_q;
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      opsel_q     <= '0;
      tag_q       <= '0;
      md_tag_q    <= '0;
      md_start_q  <= 1'b0;
      md_is_div_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      opsel_q     <= opsel_d;
      tag_q       <= tag_d;
      md_tag_q    <= md_tag_d;
      md_start_q  <= md_start_d;
      md_is_div_q <= md_is_div_d;
    end
  end

  assign InReady    = in_ready;
  assign StageEn    = {NUM_STAGES{advance}};
  assign StageValid = valid_q;
  assign StageOpSel = opsel_q;
  assign MdStart    = md_start_q;
  assign MdIsDiv    = md_is_div_q;
  assign OutValid   = valid_q[NUM_STAGES-1];
  assign OutTag     = tag_q[NUM_STAGES-1];
  assign Busy       = (|valid_q) | ~idle;

`ifdef FPU_SEQ_PERF_CNT_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating accept and stall-cycle counters
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (!advance && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign IssueCount = issue_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed testbench for fpu_issue_sequencer with an in-order result scoreboard.
module tb_fpu_issue_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned TW = 4;

  logic          Clk;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [1:0]    InOp;
  logic [TW-1:0] InTag;
  logic [NS-1:0] StageEn;
  logic [NS-1:0] StageValid;
  logic [NS-1:0] StageOpSel;
  logic          MdStart;
  logic          MdIsDiv;
  logic          MdDone;
  logic          OutValid;
  logic          OutReady;
  logic [TW-1:0] OutTag;
  logic          Busy;
`ifdef FPU_SEQ_PERF_CNT_EN
  logic [15:0]   IssueCount;
  logic [15:0]   StallCount;
`endif

  fpu_issue_sequencer #(.NUM_STAGES(NS), .MERGE_STAGE(2), .TAG_WIDTH(TW)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InOp(InOp),
    .InTag(InTag), .StageEn(StageEn), .StageValid(StageValid), .StageOpSel(StageOpSel),
    .MdStart(MdStart), .MdIsDiv(MdIsDiv), .MdDone(MdDone), .OutValid(OutValid),
    .OutReady(OutReady), .OutTag(OutTag), .Busy(Busy)
`ifdef FPU_SEQ_PERF_CNT_EN
    , .IssueCount(IssueCount), .StallCount(StallCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic          opsel;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;
  bit   lat_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic look();
    #1;
  endtask

  // Sample outputs mid-cycle, retire results against the scoreboard, move to next negedge
  task automatic cycle();
    exp_t e;
    #1;
    if (OutValid && OutReady) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_tag", 32'(OutTag), 32'(e.tag));
        check("out_opsel", 32'(StageOpSel[NS-1]), 32'(e.opsel));
        if (e.due >= 0) check("out_cycle", 32'(cyc_n), 32'(e.due));
      end
    end
    @(negedge Clk);
    cyc_n++;
  endtask

  // Present one request for one cycle; it must be accepted
  task automatic issue(input logic [1:0] op, input logic [TW-1:0] tag);
    exp_t e;
    InValid = 1'b1;
    InOp    = op;
    InTag   = tag;
    #1;
    check("in_ready", 32'(InReady), 32'd1);
    e.tag   = tag;
    e.opsel = op[1];
    e.due   = lat_chk ? (cyc_n + int'(NS)) : -1;
    if (InReady) sb.push_back(e);
    cycle();
    InValid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InOp = 2'b00; InTag = '0; MdDone = 1'b0; OutReady = 1'b1;
    @(negedge Clk);
    cycle(); cycle();
    look();
    check("rst_valid", 32'(StageValid), 32'h0);
    check("rst_opsel", 32'(StageOpSel), 32'h0);
    check("rst_mdstart", 32'(MdStart), 32'd0);
    check("rst_mdisdiv", 32'(MdIsDiv), 32'd0);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    cycle();

    // Three back-to-back adds, four-cycle latency each
    lat_chk = 1'b1;
    issue(2'b00, 4'd1); issue(2'b00, 4'd2); issue(2'b00, 4'd3);
    look();
    check("t1_valid", 32'(StageValid), 32'h7);
    check("t1_opsel", 32'(StageOpSel), 32'h0);
    check("t1_en", 32'(StageEn), 32'hF);
    drain(20);
    lat_chk = 1'b0;

    // Output stall holds every stage and blocks issue
    issue(2'b00, 4'd5);
    cycle(); cycle(); cycle();
    OutReady = 1'b0;
    InValid = 1'b1; InOp = 2'b00; InTag = 4'd9;
    for (int k = 0; k < 3; k++) begin
      look();
      check("t2_outvalid", 32'(OutValid), 32'd1);
      check("t2_outtag", 32'(OutTag), 32'd5);
      check("t2_en", 32'(StageEn), 32'h0);
      check("t2_inready", 32'(InReady), 32'd0);
      cycle();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    look();
    check("t2_rel_valid", 32'(OutValid), 32'd1);
    check("t2_rel_en", 32'(StageEn), 32'hF);
    cycle();
    look();
    check("t2_after", 32'(OutValid), 32'd0);
    drain(10);

    // Add then mul, MdDone one cycle after MdStart
    issue(2'b00, 4'd1); issue(2'b10, 4'd2);
    look();
    check("t3_mdstart", 32'(MdStart), 32'd1);
    check("t3_isdiv", 32'(MdIsDiv), 32'd0);
    check("t3_inready", 32'(InReady), 32'd0);
    cycle();
    MdDone = 1'b1;
    look();
    check("t3_valid_pre", 32'(StageValid), 32'h4);
    cycle();
    MdDone = 1'b0;
    look();
    check("t3_valid_inj", 32'(StageValid), 32'hC);
    check("t3_opsel_inj", 32'(StageOpSel), 32'h4);
    check("t3_inready_after", 32'(InReady), 32'd1);
    cycle();
    drain(10);

    // MdDone while an older add still sits before the merge stage: held then injected
    issue(2'b00, 4'd3); issue(2'b10, 4'd4);
    MdDone = 1'b1;
    look();
    check("t3b_mdstart", 32'(MdStart), 32'd1);
    check("t3b_valid", 32'(StageValid), 32'h2);
    cycle();
    MdDone = 1'b0;
    look();
    check("t3b_hold_valid", 32'(StageValid), 32'h4);
    check("t3b_hold_ready", 32'(InReady), 32'd0);
    cycle();
    look();
    check("t3b_inj_valid", 32'(StageValid), 32'hC);
    check("t3b_inj_opsel", 32'(StageOpSel), 32'h4);
    check("t3b_inready", 32'(InReady), 32'd1);
    cycle();
    drain(10);

    // Div result arrives during an output stall
    issue(2'b00, 4'd6); issue(2'b11, 4'd7);
    look();
    check("t4_mdstart", 32'(MdStart), 32'd1);
    check("t4_isdiv", 32'(MdIsDiv), 32'd1);
    cycle();
    cycle();
    OutReady = 1'b0; MdDone = 1'b1;
    look();
    check("t4_outvalid", 32'(OutValid), 32'd1);
    check("t4_outtag", 32'(OutTag), 32'd6);
    cycle();
    MdDone = 1'b0;
    look();
    check("t4_hold_valid", 32'(StageValid), 32'h8);
    check("t4_hold_ready", 32'(InReady), 32'd0);
    check("t4_busy", 32'(Busy), 32'd1);
    cycle();
    OutReady = 1'b1;
    look();
    check("t4_rel_en", 32'(StageEn), 32'hF);
    cycle();
    look();
    check("t4_inj_valid", 32'(StageValid), 32'h4);
    check("t4_inj_opsel", 32'(StageOpSel), 32'h4);
    check("t4_inready", 32'(InReady), 32'd1);
    cycle();
    drain(10);

    // OutReady rises in the same cycle as MdDone: immediate inject
    issue(2'b00, 4'd8); issue(2'b10, 4'd9);
    cycle(); cycle();
    OutReady = 1'b0;
    cycle();
    OutReady = 1'b1; MdDone = 1'b1;
    look();
    check("t4b_inready", 32'(InReady), 32'd0);
    cycle();
    MdDone = 1'b0;
    look();
    check("t4b_valid", 32'(StageValid), 32'h4);
    check("t4b_opsel", 32'(StageOpSel), 32'h4);
    cycle();
    drain(10);

    // Reset with a mul outstanding and two adds in flight; late MdDone ignored
    issue(2'b00, 4'd1); issue(2'b00, 4'd2); issue(2'b10, 4'd3);
    look();
    check("t5_mdstart", 32'(MdStart), 32'd1);
    check("t5_valid", 32'(StageValid), 32'h6);
    Reset = 1'b1;
    sb.delete();
    look();
    check("t5_rst_valid", 32'(StageValid), 32'h0);
    check("t5_rst_mdstart", 32'(MdStart), 32'd0);
    cycle();
    Reset = 1'b0; MdDone = 1'b1;
    look();
    check("t5_inready", 32'(InReady), 32'd1);
    cycle();
    MdDone = 1'b0;
    look();
    check("t5_late_valid", 32'(StageValid), 32'h0);
    check("t5_late_busy", 32'(Busy), 32'd0);
    check("t5_late_ready", 32'(InReady), 32'd1);
    lat_chk = 1'b1;
    issue(2'b01, 4'd10);
    drain(10);
    lat_chk = 1'b0;

`ifdef FPU_SEQ_PERF_CNT_EN
    // Five accepts and exactly three stall cycles, then counter saturation
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    look();
    check("pc_rst_issue", 32'(IssueCount), 32'd0);
    check("pc_rst_stall", 32'(StallCount), 32'd0);
    for (int k = 0; k < 5; k++) issue(2'b00, TW'(k + 1));
    OutReady = 1'b0;
    cycle(); cycle(); cycle();
    OutReady = 1'b1;
    drain(20);
    look();
    check("pc_issue", 32'(IssueCount), 32'd5);
    check("pc_stall", 32'(StallCount), 32'd3);
    issue(2'b00, 4'd11);
    cycle(); cycle(); cycle();
    OutReady = 1'b0;
    for (int k = 0; k < 70000; k++) cycle();
    look();
    check("pc_stall_sat", 32'(StallCount), 32'hFFFF);
    OutReady = 1'b1;
    drain(10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
